// File: rtl/cic_comb_dec_if.sv
// Sample stream bundle: a signed data word qualified by a one-cycle valid strobe.
// The producer drives through 'master', the consumer reads through 'slave'.
interface cic_comb_dec_if #(
  parameter int W = 16
);
  logic signed [W-1:0] data;
  logic                val;

  modport master (output data, output val);
  modport slave  (input  data, input  val);
endinterface

// File: rtl/cic_comb_dec.sv
// Decimating comb section of a CIC decimator: keeps every R-th valid integrator
// sample, runs it through N differential-delay-1 combs, truncates to Wout bits.
module cic_comb_dec #(
  parameter int Win  = 16,
  parameter int Wg   = 22,
  parameter int R    = 8,
  parameter int N    = 3,
  parameter int Wout = 16
) (
  input  logic             clk,
  input  logic             rst,
  cic_comb_dec_if.slave    in_if,
  cic_comb_dec_if.master   out_if
);

  localparam int W  = Wg + Win;
  localparam int CW = $clog2(R);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic signed [W-1:0] x_q [0:N];
  logic signed [W-1:0] x_d [0:N];
  logic signed [W-1:0] d_q [0:N-1];
  logic signed [W-1:0] d_d [0:N-1];
  logic                v_q [0:N];
  logic                v_d [0:N];
  logic signed [Wout-1:0] data_out_q, data_out_d;
  logic                   val_out_q, val_out_d;
  logic                   accept;

  assign accept = in_if.val && (cnt_q == CW'(R - 1));

  // x[0] is the decimation register; x[k] is the output of comb stage k.
  // Delay registers only move on valid tokens, so input gaps are invisible.
  always_comb begin
    cnt_d = cnt_q;
    if (in_if.val) begin
      cnt_d = accept ? '0 : cnt_q + CW'(1);
    end

    x_d = x_q;
    d_d = d_q;
    v_d[0] = accept;
    if (accept) begin
      x_d[0] = in_if.data;
    end
    for (int k = 1; k <= N; k++) begin
      v_d[k] = v_q[k-1];
      if (v_q[k-1]) begin
        x_d[k]   = x_q[k-1] - d_q[k-1];
        d_d[k-1] = x_q[k-1];
      end
    end

    data_out_d = data_out_q;
    val_out_d  = v_q[N];
    if (v_q[N]) begin
      data_out_d = x_q[N][W-1 -: Wout];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      data_out_q <= '0;
      val_out_q  <= 1'b0;
      for (int k = 0; k <= N; k++) begin
        x_q[k] <= '0;
        v_q[k] <= 1'b0;
      end
      for (int k = 0; k < N; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      val_out_q  <= val_out_d;
      x_q        <= x_d;
      v_q        <= v_d;
      d_q        <= d_d;
    end
  end

  assign out_if.data = data_out_q;
  assign out_if.val  = val_out_q;

endmodule

// File: tb/tb_cic_comb_dec.sv
// Scoreboard bench for cic_comb_dec: a reference model built from the kept-sample
// history (N-th finite difference, binomial form) predicts each output and its cycle.
module tb_cic_comb_dec;

  localparam int WIN  = 16;
  localparam int WG   = 22;
  localparam int R    = 8;
  localparam int N    = 3;
  localparam int WOUT = 16;
  localparam int W    = WG + WIN;

  typedef struct {
    logic signed [WOUT-1:0] data;
    int                     cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   valid_cnt = 0;

  exp_t                sb [$];
  logic signed [W-1:0] kept [$];

  cic_comb_dec_if #(.W(W))    in_if ();
  cic_comb_dec_if #(.W(WOUT)) out_if ();

  cic_comb_dec #(
    .Win(WIN), .Wg(WG), .R(R), .N(N), .Wout(WOUT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .in_if (in_if),
    .out_if(out_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Newest output = sum_j (-1)^j C(N,j) kept[m-j], zero history before reset,
  // reduced modulo 2^W, then the top WOUT bits.
  function automatic logic signed [WOUT-1:0] model_out();
    longint     acc = 0;
    longint     coef = 1;
    int         m = kept.size() - 1;
    logic [63:0] t;
    for (int j = 0; j <= N; j++) begin
      if (m - j >= 0) begin
        if (j % 2 == 1) acc = acc - coef * longint'(kept[m-j]);
        else            acc = acc + coef * longint'(kept[m-j]);
      end
      coef = coef * (N - j) / (j + 1);
    end
    t = acc;
    return t[W-1 -: WOUT];
  endfunction

  function automatic logic signed [W-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[W-1:0];
  endfunction

  task automatic drive(input logic signed [W-1:0] d, input logic v);
    exp_t e;
    @(posedge clk);
    #1;
    in_if.data = d;
    in_if.val  = v;
    if (v && rst) begin
      valid_cnt++;
      if (valid_cnt % R == 0) begin
        kept.push_back(d);
        e.data = model_out();
        e.cyc  = cyc + N + 2;
        sb.push_back(e);
      end
    end
  endtask

  task automatic do_reset(input int cycles, input logic v);
    @(posedge clk);
    #1;
    rst = 1'b0;
    kept.delete();
    sb.delete();
    valid_cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      in_if.val  = v;
      in_if.data = rand_word();
      @(posedge clk);
      #1;
    end
    in_if.val = 1'b0;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      checks++;
      if (out_if.val !== 1'b0 || out_if.data !== '0) begin
        errors++;
        $display("[TB] FAIL reset_state: val_out=%b data_out=%0d, required 0/0 at cycle %0d",
                 out_if.val, out_if.data, cyc);
      end
    end else if (out_if.val === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_output: data_out=%0d at cycle %0d, no output expected",
                 out_if.data, cyc);
      end else begin
        e = sb.pop_front();
        if (out_if.data !== e.data) begin
          errors++;
          $display("[TB] FAIL data_out: got %0d, expected %0d at cycle %0d",
                   out_if.data, e.data, cyc);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("[TB] FAIL latency: val_out at cycle %0d, expected cycle %0d", cyc, e.cyc);
        end
      end
    end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL missing_output: no val_out, expected data_out=%0d at cycle %0d, now %0d",
               sb[0].data, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
  end

  initial begin
    logic signed [W-1:0] ramp;
    in_if.data = '0;
    in_if.val  = 1'b0;

    // Reset held with live valid input: outputs must stay zero.
    do_reset(6, 1'b1);
    drive('0, 1'b0);

    // Step response with val_in held high.
    for (int i = 0; i < 8 * R; i++) drive(38'sd4194304, 1'b1);

    // Same step with val_in on every third cycle.
    do_reset(2, 1'b0);
    for (int i = 0; i < 3 * 8 * R; i++) drive(38'sd4194304, (i % 3 == 0));

    // Ramp crossing the positive overflow point.
    do_reset(2, 1'b0);
    ramp = 38'h20_0000_0000 - 38'd20000;
    for (int i = 0; i < 10 * R; i++) begin
      drive(ramp, 1'b1);
      ramp = ramp + 38'sd1000;
    end

    // Single -1 impulse landing on a decimation point.
    do_reset(2, 1'b0);
    for (int i = 0; i < R - 1; i++) drive('0, 1'b1);
    drive(-38'sd1, 1'b1);
    for (int i = 0; i < 5 * R; i++) drive('0, 1'b1);

    // Random data and random valid activity.
    do_reset(2, 1'b0);
    for (int i = 0; i < 400; i++) drive(rand_word(), 1'($urandom_range(0, 1)));

    // Reset while a freshly accepted token is still in the pipeline.
    for (int i = 0; i < 4 * R; i++) begin
      drive(rand_word(), 1'b1);
      if (valid_cnt % R == 0) break;
    end
    drive(rand_word(), 1'b1);
    do_reset(1, 1'b1);
    for (int i = 0; i < 300; i++) drive(rand_word(), 1'($urandom_range(0, 3) != 0));

    // Drain and confirm every expected output appeared.
    for (int i = 0; i < N + 6; i++) drive('0, 1'b0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d outputs still pending, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cic_comb_dec.md
# cic_comb_dec

Decimating comb section of the CIC decimator. It sits directly after the integrator chain and takes the full-growth `Wg+Win`-bit integrator output with its validation strobe. It keeps one of every `R` valid samples and passes the kept samples through `N` pipelined comb (differentiator) stages with differential delay 1. The result is truncated to `Wout` bits and output with a one-cycle validation pulse per decimated sample.

## Interface
- `Win`, default 16: CIC input sample width.
- `Wg`, default 22: bit growth; internal datapath width is `Wg+Win` (38 bits by default).
- `R`, default 8: decimation factor, 2 ≤ R ≤ 256.
- `N`, default 3: number of comb stages, 1 ≤ N ≤ 8.
- `Wout`, default 16: output width, `Wout` ≤ `Wg+Win`.
- `clk`, input, 1: clock. All registers update on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `data_in`, input, `Wg+Win`, signed: integrator-chain output.
- `val_in`, input, 1: `data_in` is valid this cycle.
- `data_out`, output, `Wout`, signed: decimated, differentiated, truncated sample.
- `val_out`, output, 1: single-cycle pulse marking a valid `data_out`.

## Operation
- Reset (`rst`=0, asynchronous) clears the following to 0, and they stay 0 while `rst`=0:
  - decimation counter `cnt`
  - decimation register and its valid bit
  - all comb output registers, comb delay registers and stage valid bits
  - `data_out` and `val_out`
- Decimation counter:
  - `cnt` (width `clog2(R)`) increments on every cycle with `val_in`=1.
  - When `val_in`=1 and `cnt`=R−1: the sample is accepted and `cnt` wraps to 0.
  - Result: the R-th, 2R-th, … valid samples after reset are kept.
  - When `val_in`=0, `cnt` holds.
- Decimation stage: on an accepted sample, `x0 <= data_in` and `v0 <= 1`. Otherwise `v0 <= 0` and `x0` holds.
- Comb stage k (k = 1..N), with input `x(k-1)` and `v(k-1)`:
  - If `v(k-1)`=1: `y_k <= x(k-1) − d_k`, `d_k <= x(k-1)`, `v_k <= 1`.
  - Otherwise: `y_k` and `d_k` hold, `v_k <= 0`.
  - `x_k` = `y_k`.
- Arithmetic:
  - All subtraction is two's-complement modulo 2^(Wg+Win), with no saturation.
  - Wrap-around in the integrators and combs is intentional and cancels out. Saturating here is a bug.
- Output stage:
  - If `v_N`=1: `data_out <= y_N[Wg+Win-1 : Wg+Win-Wout]` (truncation, i.e. floor toward −∞) and `val_out <= 1`.
  - Otherwise `val_out <= 0` and `data_out` holds its last value.
- The pipeline never stalls. Tokens advance one stage per cycle regardless of `val_in` activity.
- Stage delay registers advance only on valid tokens, so gaps in `val_in` do not change the results.

## Timing
- Latency: accepted sample at edge t → `val_out`=1 in the cycle after edge t+N+2. That is N+2 clocks, 5 for the default N=3.
- `val_out` is high for exactly one cycle per accepted sample.
- Minimum `val_out` spacing is R cycles when `val_in` is held high.
- `val_in` may toggle arbitrarily, including every cycle and with long gaps. Only valid cycles count toward R.
- Reset mid-operation:
  - In-flight tokens are discarded and `val_out` drops immediately, asynchronously.
  - After release, the first `val_out` occurs N+2 cycles after the R-th new valid input.
  - The first N outputs after reset reflect zero history. This is expected CIC start-up transient.
- `rst` release is synchronised externally. No behaviour is defined for release coincident with `val_in`.

## Test plan
- Reset values:
  - Drive `rst`=0 with `val_in`=1 and random `data_in`.
  - Required: `data_out`=0 and `val_out`=0 throughout.
  - Release: the first `val_out` pulse appears 8+5−1 = 12 clocks after the first valid input (defaults).
- Step response (defaults):
  - Hold `data_in` = 2^22 with `val_in`=1.
  - Required: successive `val_out` pulses, 8 cycles apart, carry `data_out` = 1, −2, 1, 0, 0, …
- Gapped valid:
  - Repeat the step test with `val_in` asserted every 3rd cycle.
  - Required: identical `data_out` sequence, with pulses 24 cycles apart.
- Wrap-around:
  - Feed a ramp `data_in` += 1000 per valid cycle, starting at 2^37 − 20000, so it overflows past the max positive value.
  - Required: `y_1` = 8000 on every token, including across the overflow.
  - Required: `data_out` settles to 0 after 3 outputs, with no glitch at the overflow.
- Negative truncation:
  - Construct comb output −1: a single-sample impulse of −1 at a decimation point, applied to `data_in` with zero history.
  - Required: `data_out` = −1 (floor), not 0.
- Mid-operation reset:
  - Assert `rst` for 1 cycle with 2 tokens in flight.
  - Required: no `val_out` from those tokens; `cnt` restarts, with the next pulse only after 8 new valid inputs plus latency.
